// File: rtl/uart_tx_cfg_if.sv
// Byte-input handshake between a bus-side producer and the UART transmitter.
interface uart_tx_cfg_if #(
   parameter int unsigned DATA_BITS = 8
) ();

   logic [DATA_BITS-1:0] s_data;
   logic                 s_valid;
   logic                 s_ready;

   // Producer side: offers words, observes back-pressure.
   modport master (
      output s_data,
      output s_valid,
      input  s_ready
   );

   // Transmitter side: accepts words when it has FIFO room.
   modport slave (
      input  s_data,
      input  s_valid,
      output s_ready
   );

endinterface

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: FIFO-fed, N data bits, optional parity,
// 1 or 2 stop bits, back-to-back frames while the FIFO holds data.
// tx is a registered copy of the bit selected by the FSM, so the line lags
// the FSM state by exactly one cycle; frame_done is delayed to match.
module uart_tx_cfg #(
   parameter int unsigned CLKS_PER_BIT = 100,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                              clk,
   input  logic                              rst_n,
   uart_tx_cfg_if.slave                      s,
   output logic                              tx,
   output logic                              busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
   output logic                              frame_done
);

   localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT) + 1;
   localparam int unsigned IDX_W  = $clog2(DATA_BITS + 1);
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PAR,
      ST_STOP
   } state_t;

   state_t               state;
   logic [CNT_W-1:0]     bit_cnt;
   logic [IDX_W-1:0]     bit_idx;
   logic [DATA_BITS-1:0] shift;
   logic                 par_bit;
   logic                 stop_end;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;

   logic                 bit_end_c;
   logic                 last_data_c;
   logic                 last_stop_c;
   logic                 stop_done_c;
   logic                 empty_c;
   logic                 push_c;
   logic                 pop_c;
   logic [FCNT_W-1:0]    count_n_c;
   logic [DATA_BITS-1:0] head_c;
   logic                 head_par_c;
   logic                 tx_c;
   logic                 busy_c;

   // Bit timing, FIFO handshake and the line value for the current state.
   always_comb begin
      bit_end_c   = (bit_cnt == CNT_W'(CLKS_PER_BIT - 1));
      last_data_c = (bit_idx == IDX_W'(DATA_BITS - 1));
      last_stop_c = (bit_idx == IDX_W'(STOP_BITS - 1));
      stop_done_c = (state == ST_STOP) && bit_end_c && last_stop_c;
      empty_c     = (fifo_count == '0);
      push_c      = s.s_valid && s.s_ready;
      pop_c       = !empty_c && ((state == ST_IDLE) || stop_done_c);
      head_c      = mem[rd_ptr];
      head_par_c  = (PARITY == 2) ? ~^head_c : ^head_c;

      count_n_c = fifo_count;
      case ({push_c, pop_c})
         2'b10:   count_n_c = fifo_count + FCNT_W'(1);
         2'b01:   count_n_c = fifo_count - FCNT_W'(1);
         default: count_n_c = fifo_count;
      endcase

      tx_c = 1'b1;
      case (state)
         ST_IDLE:  tx_c = 1'b1;
         ST_START: tx_c = 1'b0;
         ST_DATA:  tx_c = shift[0];
         ST_PAR:   tx_c = par_bit;
         ST_STOP:  tx_c = 1'b1;
         default:  tx_c = 1'b1;
      endcase

      // A frame is still in flight through the tx register while the FSM
      // is non-idle, so this stays high until frame_done rises.
      busy_c = pop_c || (state != ST_IDLE) || (count_n_c != '0);
   end

   // FIFO storage; contents need no reset because pointers define validity.
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem[wr_ptr] <= s.s_data;
      end
   end

   // FIFO pointers, occupancy and registered ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         s.s_ready  <= 1'b1;
      end else begin
         if (push_c) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop_c) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         fifo_count <= count_n_c;
         s.s_ready  <= (count_n_c != FCNT_W'(FIFO_DEPTH));
      end
   end

   // Frame FSM with bit-time and bit-index counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         bit_cnt    <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         par_bit    <= 1'b0;
         tx         <= 1'b1;
         busy       <= 1'b0;
         stop_end   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         tx         <= tx_c;
         busy       <= busy_c;
         stop_end   <= stop_done_c;
         frame_done <= stop_end;

         case (state)
            ST_IDLE: begin
               bit_cnt <= '0;
               bit_idx <= '0;
               if (pop_c) begin
                  shift   <= head_c;
                  par_bit <= head_par_c;
                  state   <= ST_START;
               end
            end

            ST_START: begin
               if (bit_end_c) begin
                  bit_cnt <= '0;
                  state   <= ST_DATA;
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end

            ST_DATA: begin
               if (bit_end_c) begin
                  bit_cnt <= '0;
                  shift   <= shift >> 1;
                  if (last_data_c) begin
                     bit_idx <= '0;
                     state   <= (PARITY != 0) ? ST_PAR : ST_STOP;
                  end else begin
                     bit_idx <= bit_idx + IDX_W'(1);
                  end
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end

            ST_PAR: begin
               if (bit_end_c) begin
                  bit_cnt <= '0;
                  state   <= ST_STOP;
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end

            ST_STOP: begin
               if (bit_end_c) begin
                  bit_cnt <= '0;
                  if (last_stop_c) begin
                     bit_idx <= '0;
                     // Chain straight into the next frame when data waits.
                     if (pop_c) begin
                        shift   <= head_c;
                        par_bit <= head_par_c;
                        state   <= ST_START;
                     end else begin
                        state   <= ST_IDLE;
                     end
                  end else begin
                     bit_idx <= bit_idx + IDX_W'(1);
                  end
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end

            default: begin
               state   <= ST_IDLE;
               bit_cnt <= '0;
               bit_idx <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: several configurations side by side,
// each exercised by its own scenario task against hand-built waveforms.
module tb_uart_tx_cfg;

   logic clk;
   logic rst_n;
   logic rst_a;

   int checks   = 0;
   int failures = 0;
   int sel      = 0;

   // 8N1 @4, even @4, odd @4, 7D2S @4, 8N1 @1
   uart_tx_cfg_if #(.DATA_BITS(8)) if_a ();
   uart_tx_cfg_if #(.DATA_BITS(8)) if_e ();
   uart_tx_cfg_if #(.DATA_BITS(8)) if_o ();
   uart_tx_cfg_if #(.DATA_BITS(7)) if_7 ();
   uart_tx_cfg_if #(.DATA_BITS(8)) if_f ();

   logic       tx_a, busy_a, fd_a;
   logic       tx_e, busy_e, fd_e;
   logic       tx_o, busy_o, fd_o;
   logic       tx_7, busy_7, fd_7;
   logic       tx_f, busy_f, fd_f;
   logic [2:0] fc_a, fc_e, fc_o, fc_7, fc_f;

   uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
      u_a (.clk(clk), .rst_n(rst_a), .s(if_a.slave), .tx(tx_a), .busy(busy_a),
           .fifo_count(fc_a), .frame_done(fd_a));
   uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
      u_e (.clk(clk), .rst_n(rst_n), .s(if_e.slave), .tx(tx_e), .busy(busy_e),
           .fifo_count(fc_e), .frame_done(fd_e));
   uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4))
      u_o (.clk(clk), .rst_n(rst_n), .s(if_o.slave), .tx(tx_o), .busy(busy_o),
           .fifo_count(fc_o), .frame_done(fd_o));
   uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4))
      u_7 (.clk(clk), .rst_n(rst_n), .s(if_7.slave), .tx(tx_7), .busy(busy_7),
           .fifo_count(fc_7), .frame_done(fd_7));
   uart_tx_cfg #(.CLKS_PER_BIT(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
      u_f (.clk(clk), .rst_n(rst_n), .s(if_f.slave), .tx(tx_f), .busy(busy_f),
           .fifo_count(fc_f), .frame_done(fd_f));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observation mux over the selected instance.
   logic       o_tx, o_fd, o_busy, o_ready;
   logic [2:0] o_cnt;
   always_comb begin
      o_tx = 1'b1; o_fd = 1'b0; o_busy = 1'b0; o_ready = 1'b0; o_cnt = '0;
      case (sel)
         0: begin o_tx = tx_a; o_fd = fd_a; o_busy = busy_a; o_ready = if_a.s_ready; o_cnt = fc_a; end
         1: begin o_tx = tx_e; o_fd = fd_e; o_busy = busy_e; o_ready = if_e.s_ready; o_cnt = fc_e; end
         2: begin o_tx = tx_o; o_fd = fd_o; o_busy = busy_o; o_ready = if_o.s_ready; o_cnt = fc_o; end
         3: begin o_tx = tx_7; o_fd = fd_7; o_busy = busy_7; o_ready = if_7.s_ready; o_cnt = fc_7; end
         4: begin o_tx = tx_f; o_fd = fd_f; o_busy = busy_f; o_ready = if_f.s_ready; o_cnt = fc_f; end
         default: ;
      endcase
   end

   logic cap_tx [0:599];
   logic cap_fd [0:599];
   logic cap_bs [0:599];
   logic exp_tx [0:599];
   logic exp_fd [0:599];
   int   ep;

   task automatic drive(input int s, input logic v, input logic [8:0] w);
      case (s)
         0: begin if_a.s_valid = v; if_a.s_data = w[7:0]; end
         1: begin if_e.s_valid = v; if_e.s_data = w[7:0]; end
         2: begin if_o.s_valid = v; if_o.s_data = w[7:0]; end
         3: begin if_7.s_valid = v; if_7.s_data = w[6:0]; end
         4: begin if_f.s_valid = v; if_f.s_data = w[7:0]; end
         default: ;
      endcase
   endtask

   // Record n samples of the selected instance, one per cycle, #1 after the edge.
   task automatic capture(input int n);
      for (int i = 0; i < n; i++) begin
         cap_tx[i] = o_tx;
         cap_fd[i] = o_fd;
         cap_bs[i] = o_busy;
         @(posedge clk); #1;
      end
   endtask

   task automatic exp_clear();
      for (int i = 0; i < 600; i++) begin
         exp_tx[i] = 1'b1;
         exp_fd[i] = 1'b0;
      end
      ep = 0;
   endtask

   task automatic exp_bit(input logic b, input int cpb);
      for (int c = 0; c < cpb; c++) begin
         exp_tx[ep] = b;
         ep++;
      end
   endtask

   // Reference frame: start, LSB-first data, optional parity, stop bits.
   task automatic exp_frame(input logic [8:0] w, input int db, input int par,
                            input int sb, input int cpb);
      int ones;
      ones = 0;
      exp_bit(1'b0, cpb);
      for (int b = 0; b < db; b++) begin
         exp_bit(w[b], cpb);
         if (w[b]) ones++;
      end
      if (par == 1) exp_bit(((ones % 2) == 1), cpb);
      if (par == 2) exp_bit(((ones % 2) == 0), cpb);
      for (int k = 0; k < sb; k++) exp_bit(1'b1, cpb);
      exp_fd[ep] = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rst_a = 1'b0;
      drive(0, 1'b0, 9'h0); drive(1, 1'b0, 9'h0); drive(2, 1'b0, 9'h0);
      drive(3, 1'b0, 9'h0); drive(4, 1'b0, 9'h0);
      sel = 0;
      #12;
      checks++; if (o_tx !== 1'b1)    begin failures++; $display("FAIL rst_tx: got %b want 1", o_tx); end
      checks++; if (o_busy !== 1'b0)  begin failures++; $display("FAIL rst_busy: got %b want 0", o_busy); end
      checks++; if (o_fd !== 1'b0)    begin failures++; $display("FAIL rst_frame_done: got %b want 0", o_fd); end
      checks++; if (o_cnt !== 3'd0)   begin failures++; $display("FAIL rst_count: got %0d want 0", o_cnt); end
      checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b want 1", o_ready); end
      #10;
      rst_n = 1'b1; rst_a = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_8n1();
      int nb, fb, np;
      sel = 0;
      drive(0, 1'b1, 9'h0A5);
      @(posedge clk); #1;
      drive(0, 1'b0, 9'h0A5);
      checks++; if (o_tx !== 1'b1) begin failures++; $display("FAIL t1_latency: tx got %b want 1 one edge after accept", o_tx); end
      capture(46);
      exp_clear(); ep = 2; exp_frame(9'h0A5, 8, 0, 1, 4);
      nb = 0; fb = 0;
      for (int i = 0; i < 46; i++) if (cap_tx[i] !== exp_tx[i]) begin if (nb == 0) fb = i; nb++; end
      checks++; if (nb != 0) begin failures++; $display("FAIL t1_tx_wave: %0d bad cycles, first %0d got %b want %b", nb, fb, cap_tx[fb], exp_tx[fb]); end
      nb = 0; fb = 0; np = 0;
      for (int i = 0; i < 46; i++) begin
         if (cap_fd[i] === 1'b1) np++;
         if (cap_fd[i] !== exp_fd[i]) begin if (nb == 0) fb = i; nb++; end
      end
      checks++; if (nb != 0) begin failures++; $display("FAIL t1_fd_wave: %0d bad cycles, first %0d got %b want %b", nb, fb, cap_fd[fb], exp_fd[fb]); end
      checks++; if (np != 1) begin failures++; $display("FAIL t1_fd_pulses: got %0d want 1", np); end
      checks++; if (cap_bs[41] !== 1'b1) begin failures++; $display("FAIL t1_busy_in_stop: got %b want 1", cap_bs[41]); end
      checks++; if (cap_bs[42] !== 1'b0) begin failures++; $display("FAIL t1_busy_after: got %b want 0", cap_bs[42]); end
   endtask

   task automatic test_parity();
      int nb, fb, fdi;
      for (int m = 1; m <= 2; m++) begin
         sel = m;
         drive(m, 1'b1, 9'h007);
         @(posedge clk); #1;
         drive(m, 1'b0, 9'h007);
         capture(50);
         exp_clear(); ep = 2; exp_frame(9'h007, 8, m, 1, 4);
         nb = 0; fb = 0; fdi = -1;
         for (int i = 0; i < 50; i++) begin
            if (cap_fd[i] === 1'b1 && fdi < 0) fdi = i;
            if (cap_tx[i] !== exp_tx[i]) begin if (nb == 0) fb = i; nb++; end
         end
         checks++; if (nb != 0) begin failures++; $display("FAIL t2_tx_wave_mode%0d: %0d bad cycles, first %0d got %b want %b", m, nb, fb, cap_tx[fb], exp_tx[fb]); end
         checks++; if (cap_tx[38] !== ((m == 1) ? 1'b1 : 1'b0)) begin failures++; $display("FAIL t2_parity_bit_mode%0d: got %b want %b", m, cap_tx[38], (m == 1)); end
         checks++; if (fdi != 46) begin failures++; $display("FAIL t2_frame_len_mode%0d: frame_done at %0d want 46 (44-cycle frame)", m, fdi); end
      end
   endtask

   task automatic test_7d2s();
      int nb, fb, fdi;
      sel = 3;
      drive(3, 1'b1, 9'h041);
      @(posedge clk); #1;
      drive(3, 1'b0, 9'h041);
      capture(46);
      exp_clear(); ep = 2; exp_frame(9'h041, 7, 0, 2, 4);
      nb = 0; fb = 0; fdi = -1;
      for (int i = 0; i < 46; i++) begin
         if (cap_fd[i] === 1'b1 && fdi < 0) fdi = i;
         if (cap_tx[i] !== exp_tx[i]) begin if (nb == 0) fb = i; nb++; end
      end
      checks++; if (nb != 0) begin failures++; $display("FAIL t3_tx_wave: %0d bad cycles, first %0d got %b want %b", nb, fb, cap_tx[fb], exp_tx[fb]); end
      checks++; if (fdi != 42) begin failures++; $display("FAIL t3_frame_len: frame_done at %0d want 42 (40-cycle frame)", fdi); end
      checks++; if (cap_tx[30] !== 1'b1 || cap_tx[29] !== 1'b0) begin failures++; $display("FAIL t3_msb: bits6/5 got %b%b want 10", cap_tx[30], cap_tx[29]); end
   endtask

   task automatic test_back_to_back();
      logic [8:0] w [0:5];
      int k, guard, ready_bad, max_cnt, nb, fb, np;
      w[0] = 9'h011; w[1] = 9'h022; w[2] = 9'h033;
      w[3] = 9'h0C4; w[4] = 9'h055; w[5] = 9'h0E6;
      sel = 0; k = 0; guard = 0; ready_bad = 0; max_cnt = 0;
      drive(0, 1'b1, w[0]);
      fork
         begin
            while (k < 6 && guard < 1000) begin
               logic rdy;
               rdy = if_a.s_ready;
               if (int'(fc_a) > max_cnt) max_cnt = int'(fc_a);
               if (fc_a == 3'd4 && rdy !== 1'b0) ready_bad++;
               @(posedge clk);
               if (rdy) k++;
               guard++;
               #1;
               if (k < 6) drive(0, 1'b1, w[k]);
               else       drive(0, 1'b0, 9'h0);
            end
            drive(0, 1'b0, 9'h0);
         end
         capture(246);
      join
      checks++; if (k != 6) begin failures++; $display("FAIL t4_accepted: got %0d want 6 within budget", k); end
      checks++; if (max_cnt != 4) begin failures++; $display("FAIL t4_max_count: got %0d want 4", max_cnt); end
      checks++; if (ready_bad != 0) begin failures++; $display("FAIL t4_ready_full: ready high while full %0d times, want 0", ready_bad); end
      exp_clear(); ep = 3;
      for (int j = 0; j < 6; j++) exp_frame(w[j], 8, 0, 1, 4);
      nb = 0; fb = 0; np = 0;
      for (int i = 0; i < 246; i++) begin
         if (cap_fd[i] === 1'b1) np++;
         if (cap_tx[i] !== exp_tx[i] || cap_fd[i] !== exp_fd[i]) begin if (nb == 0) fb = i; nb++; end
      end
      checks++; if (nb != 0) begin failures++; $display("FAIL t4_wave: %0d bad cycles, first %0d got tx%b fd%b want tx%b fd%b", nb, fb, cap_tx[fb], cap_fd[fb], exp_tx[fb], exp_fd[fb]); end
      checks++; if (np != 6) begin failures++; $display("FAIL t4_fd_pulses: got %0d want 6", np); end
      checks++; if (o_busy !== 1'b0 || o_cnt !== 3'd0) begin failures++; $display("FAIL t4_drained: busy %b count %0d want 0 0", o_busy, o_cnt); end
   endtask

   task automatic test_mid_reset();
      int nb, fb, np;
      sel = 0;
      drive(0, 1'b1, 9'h037);
      @(posedge clk); #1; drive(0, 1'b1, 9'h011);
      @(posedge clk); #1; drive(0, 1'b1, 9'h022);
      @(posedge clk); #1; drive(0, 1'b0, 9'h0);
      repeat (17) @(posedge clk);
      #1;
      checks++; if (o_tx !== 1'b0 || o_cnt !== 3'd2) begin failures++; $display("FAIL t5_pre: tx %b count %0d want 0 2 in data bit 3", o_tx, o_cnt); end
      rst_a = 1'b0;
      #1;
      checks++; if (o_tx !== 1'b1)    begin failures++; $display("FAIL t5_tx: got %b want 1", o_tx); end
      checks++; if (o_cnt !== 3'd0)   begin failures++; $display("FAIL t5_count: got %0d want 0", o_cnt); end
      checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL t5_ready: got %b want 1", o_ready); end
      checks++; if (o_busy !== 1'b0)  begin failures++; $display("FAIL t5_busy: got %b want 0", o_busy); end
      repeat (2) @(posedge clk);
      #1;
      rst_a = 1'b1;
      capture(50);
      nb = 0; np = 0;
      for (int i = 0; i < 50; i++) begin
         if (cap_fd[i] === 1'b1) np++;
         if (cap_tx[i] !== 1'b1) nb++;
      end
      checks++; if (np != 0 || nb != 0) begin failures++; $display("FAIL t5_quiet: %0d frame_done, %0d low tx cycles, want 0 0", np, nb); end
      drive(0, 1'b1, 9'h0C3);
      @(posedge clk); #1;
      drive(0, 1'b0, 9'h0);
      capture(46);
      exp_clear(); ep = 2; exp_frame(9'h0C3, 8, 0, 1, 4);
      nb = 0; fb = 0;
      for (int i = 0; i < 46; i++) if (cap_tx[i] !== exp_tx[i] || cap_fd[i] !== exp_fd[i]) begin if (nb == 0) fb = i; nb++; end
      checks++; if (nb != 0) begin failures++; $display("FAIL t5_clean_frame: %0d bad cycles, first %0d got tx%b fd%b want tx%b fd%b", nb, fb, cap_tx[fb], cap_fd[fb], exp_tx[fb], exp_fd[fb]); end
   endtask

   task automatic test_fast();
      int nb, fb, np;
      sel = 4;
      drive(4, 1'b1, 9'h000);
      @(posedge clk); #1; drive(4, 1'b1, 9'h0FF);
      @(posedge clk); #1; drive(4, 1'b0, 9'h0);
      capture(26);
      exp_clear(); ep = 1;
      exp_frame(9'h000, 8, 0, 1, 1);
      exp_frame(9'h0FF, 8, 0, 1, 1);
      nb = 0; fb = 0; np = 0;
      for (int i = 0; i < 26; i++) begin
         if (cap_fd[i] === 1'b1) np++;
         if (cap_tx[i] !== exp_tx[i] || cap_fd[i] !== exp_fd[i]) begin if (nb == 0) fb = i; nb++; end
      end
      checks++; if (nb != 0) begin failures++; $display("FAIL t6_wave: %0d bad cycles, first %0d got tx%b fd%b want tx%b fd%b", nb, fb, cap_tx[fb], cap_fd[fb], exp_tx[fb], exp_fd[fb]); end
      checks++; if (np != 2) begin failures++; $display("FAIL t6_fd_pulses: got %0d want 2", np); end
      checks++; if (cap_fd[11] !== 1'b1 || cap_tx[11] !== 1'b0) begin failures++; $display("FAIL t6_no_gap: at 11 fd %b tx %b want 1 0", cap_fd[11], cap_tx[11]); end
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_parity();
      test_7d2s();
      test_back_to_back();
      test_mid_reset();
      test_fast();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Bound on total run time in case a scenario stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
